// File: rtl/mem_responder_pkg.sv
// Shared widths and request payload for the memory responder.
package mem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  // One captured word request: direction, byte address, store data.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core-to-memory request/response bus for the multicycle core.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] Adr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req, we, Adr, WriteData,
    input  ReadData, ready, err, busy
  );

  modport slave (
    input  req, we, Adr, WriteData,
    output ReadData, ready, err, busy
  );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one word request at a time, fixed wait states,
// read data or error returned on a single-cycle ready strobe.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          cap_q, cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [IDX_W-1:0]  idx_c;
  logic              bad_c;
  logic              mem_wr_c;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Decode the captured address: word index and misaligned/out-of-range flag.
  always_comb begin
    idx_c = cap_q.adr[IDX_W+1:2];
    bad_c = (cap_q.adr[1:0] != 2'b00) || (cap_q.adr >= ADDR_LIMIT);
  end

  // Next-state, capture, counter and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    busy_d   = busy_q;
    mem_wr_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        rdata_d = '0;
        busy_d  = 1'b0;
        if (bus.req) begin
          state_d     = WAIT;
          cnt_d       = CNT_LOAD;
          cap_d.we    = bus.we;
          cap_d.adr   = bus.Adr;
          cap_d.wdata = bus.WriteData;
          busy_d      = 1'b1;
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          // Commit point: the array is touched only on the edge into DONE.
          state_d  = DONE;
          ready_d  = 1'b1;
          err_d    = bad_c;
          rdata_d  = (!bad_c && !cap_q.we) ? mem[idx_c] : '0;
          mem_wr_c = !bad_c && cap_q.we && !reset;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rdata_d = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rdata_d = '0;
      end
    endcase
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Word array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      mem[idx_c] <= cap_q.wdata;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_WORDS=64, LATENCY=2).
module tb_mem_responder;

  logic clk;
  logic reset;

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Full transaction starting just after a rising edge; inputs are scrambled
  // after the accept edge to show the captured request is what executes.
  task automatic txn(input string name, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    bus.req = 1'b1; bus.we = w; bus.Adr = a; bus.WriteData = d;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = ~w; bus.Adr = 32'h30; bus.WriteData = 32'hFFFF_FFFF;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check($sformatf("%s busy c%0d", name, i), 32'(bus.busy), 32'd1);
      check($sformatf("%s ready c%0d", name, i), 32'(bus.ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({name, " ready c3"}, 32'(bus.ready), 32'd1);
    check({name, " err c3"}, 32'(bus.err), 32'(exp_err));
    check({name, " rdata c3"}, bus.ReadData, exp_rd);
    check({name, " busy c3"}, 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, " ready c4"}, 32'(bus.ready), 32'd0);
    check({name, " busy c4"}, 32'(bus.busy), 32'd0);
    check({name, " rdata c4"}, bus.ReadData, 32'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] exp_busy_pat;
  logic [7:0] exp_rdy_pat;

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{"wr 0x10",      1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{"rd 0x10",      1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"rd 0x12 mis",  1'b0, 32'h12,       32'h0,        32'h0,        1'b1};
    vecs[3]  = '{"wr 0x13 mis",  1'b1, 32'h13,       32'hCAFEF00D, 32'h0,        1'b1};
    vecs[4]  = '{"rerd 0x10",    1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[5]  = '{"wr 0x100 oor", 1'b1, 32'h100,      32'h55555555, 32'h0,        1'b1};
    vecs[6]  = '{"wr 0xFC",      1'b1, 32'hFC,       32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[7]  = '{"rd 0xFC",      1'b0, 32'hFC,       32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[8]  = '{"rd hi oor",    1'b0, 32'h8000_0010, 32'h0,       32'h0,        1'b1};
    vecs[9]  = '{"wr 0x0",       1'b1, 32'h0,        32'h0BADF00D, 32'h0,        1'b0};
    vecs[10] = '{"rd 0x0",       1'b0, 32'h0,        32'h0,        32'h0BADF00D, 1'b0};
    vecs[11] = '{"wr 0x20",      1'b1, 32'h20,       32'h11111111, 32'h0,        1'b0};

    // Reset held two cycles with req asserted: nothing may start.
    reset = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.Adr = 32'h10; bus.WriteData = 32'h1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst busy %0d", i), 32'(bus.busy), 32'd0);
      check($sformatf("rst ready %0d", i), 32'(bus.ready), 32'd0);
      check($sformatf("rst err %0d", i), 32'(bus.err), 32'd0);
      check($sformatf("rst rdata %0d", i), bus.ReadData, 32'd0);
    end
    reset = 1'b0;
    bus.req = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) begin
      txn(vecs[v].name, vecs[v].we, vecs[v].adr, vecs[v].wd, vecs[v].exp_rd, vecs[v].exp_err);
    end

    // Reset pulsed during WAIT of a write: aborted, no ready, no array write.
    bus.req = 1'b1; bus.we = 1'b1; bus.Adr = 32'h20; bus.WriteData = 32'h1234;
    @(posedge clk); #1;
    bus.req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort ready %0d", i), 32'(bus.ready), 32'd0);
      check($sformatf("abort busy %0d", i), 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
    end
    txn("rd 0x20 after abort", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // Reset during DONE of a write: committed data stays, ready drops next cycle.
    bus.req = 1'b1; bus.we = 1'b1; bus.Adr = 32'h40; bus.WriteData = 32'h0000_0077;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("done-rst ready", 32'(bus.ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("done-rst ready drop", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    txn("rd 0x40 after done-rst", 1'b0, 32'h40, 32'h0, 32'h0000_0077, 1'b0);

    // req held high: back-to-back reads of 0x10 accepted four cycles apart.
    exp_busy_pat = 8'b0111_0111;   // bit i-1 = cycle ci, c1..c8
    exp_rdy_pat  = 8'b0100_0100;
    bus.req = 1'b1; bus.we = 1'b0; bus.Adr = 32'h10; bus.WriteData = 32'h0;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) bus.req = 1'b0;
      @(negedge clk);
      check($sformatf("b2b busy c%0d", i), 32'(bus.busy), 32'(exp_busy_pat[i-1]));
      check($sformatf("b2b ready c%0d", i), 32'(bus.ready), 32'(exp_rdy_pat[i-1]));
      if (exp_rdy_pat[i-1]) begin
        check($sformatf("b2b rdata c%0d", i), bus.ReadData, 32'hDEADBEEF);
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
